// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes and seq_alu state encoding shared across the MIPS datapath.
package alu_ctrl_pkg;
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_BEQ  = 4'b0011;
  localparam logic [3:0] CTRL_BNE  = 4'b0100;
  localparam logic [3:0] CTRL_LUI  = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SRA  = 4'b1000;
  localparam logic [3:0] CTRL_SRAV = 4'b1001;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
  function automatic logic is_shift(input logic [3:0] c);
    return c == CTRL_SRA || c == CTRL_SRAV;
  endfunction
endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: combinational single-cycle ALU ops; shift and unknown codes yield zero.
module alu_comb_core
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             branch_o
);
  logic [WIDTH-1:0] diff;
  assign diff = a_i - b_i;
  always_comb begin
    result_o = '0;
    branch_o = 1'b0;
    case (ctrl_i)
      CTRL_AND: result_o = a_i & b_i;
      CTRL_OR:  result_o = a_i | b_i;
      CTRL_ADD: result_o = a_i + b_i;
      CTRL_BEQ: begin
        result_o = diff;
        branch_o = a_i == b_i;
      end
      CTRL_BNE: begin
        result_o = diff;
        branch_o = a_i != b_i;
      end
      CTRL_LUI: result_o = b_i << 16;
      CTRL_SUB: result_o = diff;
      CTRL_SLT: result_o = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      default:  result_o = '0;
    endcase
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: execute-stage ALU; single-cycle ops in one registered cycle,
// arithmetic right shifts iterate one bit per cycle behind a ready/done handshake.
module seq_alu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             branch_o
);
  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d, res_q, res_d, core_res, shifted;
  logic             zero_q, zero_d, br_q, br_d, done_q, done_d, core_br, accept;
  logic [SHW-1:0]   amt;
  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .ctrl_i   (ctrl_i),
    .a_i      (src1_i),
    .b_i      (src2_i),
    .result_o (core_res),
    .branch_o (core_br)
  );
  assign ready_o = !rst_i && state_q == IDLE;
  assign accept  = start_i && ready_o;
  assign amt     = src1_i[SHW-1:0];
  assign shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    res_d   = res_q;
    br_d    = br_q;
    done_d  = 1'b0;
    if (accept) begin
      if (is_shift(ctrl_i) && amt != '0) begin
        state_d = SHIFT;
        cnt_d   = amt;
        work_d  = src2_i;
      end else begin
        // a zero-amount shift is just a pass-through of the data operand
        res_d  = is_shift(ctrl_i) ? src2_i : core_res;
        br_d   = core_br;
        done_d = 1'b1;
      end
    end else if (state_q == SHIFT) begin
      work_d = shifted;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == SHW'(1)) begin
        res_d   = shifted;
        br_d    = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
    zero_d = done_d ? res_d == '0 : zero_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      br_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      br_q    <= br_d;
      done_q  <= done_d;
    end
  end
  assign done_o   = done_q;
  assign result_o = res_q;
  assign zero_o   = zero_q;
  assign branch_o = br_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed plus randomized checks of seq_alu against a cycle-level behavioural model.
module tb_seq_alu;
  logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic [3:0]  ctrl_i = '0;
  logic [31:0] src1_i = '0, src2_i = '0;
  logic        ready_o, done_o, zero_o, branch_o;
  logic [31:0] result_o;
  seq_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ctrl_i(ctrl_i),
    .src1_i(src1_i), .src2_i(src2_i), .ready_o(ready_o), .done_o(done_o),
    .result_o(result_o), .zero_o(zero_o), .branch_o(branch_o)
  );
  always #5 clk_i = ~clk_i;
  int          k = 0, m_due = -1, n_chk = 0, n_err = 0;
  logic [31:0] m_pres = '0, e_res = '0;
  logic        m_pbr = 1'b0, e_ready = 1'b0, e_done = 1'b0, e_zero = 1'b0, e_br = 1'b0, chk_en = 1'b0;
  function automatic logic [32:0] ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        br;
    br = 1'b0;
    case (c)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: begin r = a - b; br = a == b; end
      4'd4: begin r = a - b; br = a != b; end
      4'd5: r = {b[15:0], 16'h0000};
      4'd6: r = a - b;
      4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8, 4'd9: r = $unsigned($signed(b) >>> a[4:0]);
      default: r = 32'd0;
    endcase
    return {br, r};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, k, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic st, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] o;
    int          n;
    @(posedge clk_i);
    #1;
    k++;
    rst_i = r; start_i = st; ctrl_i = c; src1_i = a; src2_i = b;
    if (r) begin
      m_due = -1; e_ready = 0; e_done = 0; e_res = 0; e_zero = 0; e_br = 0;
    end else begin
      e_done = k == m_due;
      if (e_done) begin
        e_res = m_pres; e_br = m_pbr; e_zero = m_pres == 0;
      end
      e_ready = k >= m_due;
    end
    if (!r && st && e_ready) begin
      o      = ref_op(c, a, b);
      m_pres = o[31:0];
      m_pbr  = o[32];
      n      = (c == 4'd8 || c == 4'd9) ? int'(a[4:0]) : 0;
      m_due  = k + 1 + n;
    end
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask
  task automatic settle();
    @(negedge clk_i);
    #1;
  endtask
  always @(negedge clk_i) if (chk_en) begin
    chk("ready", {31'd0, ready_o}, {31'd0, e_ready});
    chk("done", {31'd0, done_o}, {31'd0, e_done});
    chk("result", result_o, e_res);
    chk("zero", {31'd0, zero_o}, {31'd0, e_zero});
    chk("branch", {31'd0, branch_o}, {31'd0, e_br});
  end
  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    settle();
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    idle();
    cyc(1'b0, 1'b1, 4'd2, 32'd5, 32'd7);
    idle();
    settle();
    chk("add_done", {31'd0, done_o}, 32'd1);
    chk("add_result", result_o, 32'd12);
    chk("add_ready", {31'd0, ready_o}, 32'd1);
    cyc(1'b0, 1'b1, 4'd8, 32'd4, 32'h8000_0000);
    for (int i = 1; i <= 5; i++) idle();
    settle();
    chk("sra4_done", {31'd0, done_o}, 32'd1);
    chk("sra4_result", result_o, 32'hF800_0000);
    cyc(1'b0, 1'b1, 4'd8, 32'd0, 32'h8000_0000);
    idle();
    settle();
    chk("sra0_done", {31'd0, done_o}, 32'd1);
    chk("sra0_result", result_o, 32'h8000_0000);
    cyc(1'b0, 1'b1, 4'd9, 32'h25, 32'h40);
    for (int i = 1; i <= 6; i++) cyc(1'b0, i == 3, 4'd2, 32'd1, 32'd1);
    settle();
    chk("srav_done", {31'd0, done_o}, 32'd1);
    chk("srav_result", result_o, 32'h2);
    cyc(1'b0, 1'b1, 4'd3, 32'h1234, 32'h1234);
    cyc(1'b0, 1'b1, 4'd4, 32'h1234, 32'h1234);
    settle();
    chk("beq_branch", {31'd0, branch_o}, 32'd1);
    chk("beq_zero", {31'd0, zero_o}, 32'd1);
    chk("beq_result", result_o, 32'd0);
    cyc(1'b0, 1'b1, 4'd4, 32'd1, 32'd2);
    settle();
    chk("bne_eq_branch", {31'd0, branch_o}, 32'd0);
    cyc(1'b0, 1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1);
    settle();
    chk("bne_branch", {31'd0, branch_o}, 32'd1);
    chk("bne_result", result_o, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 4'd5, 32'd0, 32'h0000_ABCD);
    settle();
    chk("slt_result", result_o, 32'd1);
    idle();
    settle();
    chk("lui_done", {31'd0, done_o}, 32'd1);
    chk("lui_result", result_o, 32'hABCD_0000);
    cyc(1'b0, 1'b1, 4'd8, 32'd31, 32'h8000_0000);
    for (int i = 1; i <= 9; i++) idle();
    cyc(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    idle();
    settle();
    chk("abort_ready", {31'd0, ready_o}, 32'd1);
    chk("abort_result", result_o, 32'd0);
    for (int i = 0; i < 30; i++) idle();
    cyc(1'b0, 1'b1, 4'd0, 32'hF0, 32'h3C);
    idle();
    settle();
    chk("and_result", result_o, 32'h30);
    for (int i = 0; i < 4000; i++) begin
      c = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, c, a, b);
    end
    idle();
    settle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
